// File: rtl/uop_buffer_pkg.sv
// Shared microcode-fetch definitions: bundle layout and default buffer depth.
package uop_buffer_pkg;

    localparam int unsigned UOP_BUF_SIZE_DEFAULT = 64;

    typedef struct packed {
        logic [15:0] opcode;
        logic [47:0] operands;
    } instruction_bundle;

endpackage

// File: rtl/uop_ram.sv
// Simple dual-port bundle storage: one write port, one registered read port.
// Read-before-write on a same-address collision; contents are never reset.
module uop_ram #(
    parameter int unsigned Depth = 64,
    parameter int unsigned Width = 64,
    localparam int unsigned AW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset so the array itself maps onto plain RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uop_buffer.sv
// Microcode bundle buffer: circular fill from the loader, per-slot valid bits,
// single-slot free from commit and a whole-buffer flush.
module uop_buffer
    import uop_buffer_pkg::*;
#(
    parameter int unsigned UOP_BUF_SIZE = UOP_BUF_SIZE_DEFAULT,
    localparam int unsigned AW = $clog2(UOP_BUF_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     uop_addr,
    output instruction_bundle uop,
    output logic              uop_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  instruction_bundle wr_bundle,
    output logic [AW-1:0]     wr_addr,
    input  logic              free_valid,
    input  logic [AW-1:0]     free_addr,
    input  logic              invalidate_all,
    output logic [AW:0]       num_valid
);

    logic [UOP_BUF_SIZE-1:0] valid_q, valid_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]             num_valid_q, num_valid_d;
    logic                    uop_valid_q;
    logic                    accept;
    logic                    free_eff;

    assign wr_ready = !valid_q[wr_ptr_q] && !invalidate_all;
    assign accept   = wr_valid && wr_ready;
    // Freeing an empty slot must not touch the counter.
    assign free_eff = free_valid && valid_q[free_addr] && !invalidate_all;

    always_comb begin
        valid_d     = valid_q;
        wr_ptr_d    = wr_ptr_q;
        num_valid_d = num_valid_q;
        if (invalidate_all) begin
            valid_d     = '0;
            wr_ptr_d    = '0;
            num_valid_d = '0;
        end else begin
            if (free_eff) begin
                valid_d[free_addr] = 1'b0;
            end
            if (accept) begin
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + AW'(1);
            end
            unique case ({accept, free_eff})
                2'b10:   num_valid_d = num_valid_q + (AW+1)'(1);
                2'b01:   num_valid_d = num_valid_q - (AW+1)'(1);
                default: num_valid_d = num_valid_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            num_valid_q <= '0;
            uop_valid_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            num_valid_q <= num_valid_d;
            uop_valid_q <= valid_q[uop_addr];
        end
    end

    logic [$bits(instruction_bundle)-1:0] rd_data;

    uop_ram #(
        .Depth(UOP_BUF_SIZE),
        .Width($bits(instruction_bundle))
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .we   (accept && !reset),
        .waddr(wr_ptr_q),
        .wdata(wr_bundle),
        .raddr(uop_addr),
        .rdata(rd_data)
    );

    assign uop       = instruction_bundle'(rd_data);
    assign uop_valid = uop_valid_q;
    assign wr_addr   = wr_ptr_q;
    assign num_valid = num_valid_q;

endmodule
